// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared hex decoder, NDIG common-anode
// digits, guard band between slots, frame-aligned display updates via load/ack.

module seg_scan_lz_cell (
  input  logic [3:0] nib,
  input  logic       upper_zero,
  output logic       zero_run
);
  // Set when this nibble and every more-significant nibble are zero.
  assign zero_run = upper_zero && (nib == 4'h0);
endmodule

module seg_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] value,
  input  logic              load,
  input  logic              blank_lz,
  output logic              ack,
  output logic [3:0]        hex_nib,
  input  logic [6:0]        seg_in,
  output logic [6:0]        seg_out,
  output logic [NDIG-1:0]   dig_en_n
);
  localparam int CMAX = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
  localparam int CW   = $clog2(CMAX);
  localparam int DW   = $clog2(NDIG);

  typedef enum logic {S_GUARD, S_DRIVE} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [DW-1:0]          dig, dig_nxt;
  logic [NDIG-1:0]        en_n_nxt;
  logic [NDIG-1:0][3:0]   disp, pend;
  logic                   pend_valid;
  logic                   frame_end, xfer;
  logic [NDIG:1]          hi_zero;
  logic [NDIG-1:0]        sup;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    dig_nxt   = dig;
    frame_end = 1'b0;
    case (state)
      S_GUARD: if (cnt == CW'(GUARD - 1)) begin
        cnt_nxt   = '0;
        state_nxt = S_DRIVE;
      end
      S_DRIVE: if (cnt == CW'(SCAN_DIV - 1)) begin
        cnt_nxt   = '0;
        state_nxt = S_GUARD;
        frame_end = (dig == DW'(NDIG - 1));
        dig_nxt   = frame_end ? '0 : dig + 1'b1;
      end
      default: state_nxt = S_GUARD;
    endcase
    // Enables are registered so they switch on the same edge as the state.
    en_n_nxt = '1;
    if (state_nxt == S_DRIVE) en_n_nxt[dig_nxt] = 1'b0;
  end

  assign xfer = frame_end && pend_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_GUARD;
      cnt        <= '0;
      dig        <= '0;
      dig_en_n   <= '1;
      disp       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      ack        <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dig      <= dig_nxt;
      dig_en_n <= en_n_nxt;
      ack      <= xfer;
      if (xfer) disp <= pend;
      // A load coinciding with a transfer lands in pend after the old word moves out.
      if (load) pend <= value;
      pend_valid <= load || (pend_valid && !frame_end);
    end
  end

  assign hi_zero[NDIG] = 1'b1;
  assign sup[0]        = 1'b0;

  genvar i;
  generate
    for (i = 1; i < NDIG; i++) begin : g_lz
      seg_scan_lz_cell u_cell (
        .nib        (disp[i]),
        .upper_zero (hi_zero[i+1]),
        .zero_run   (hi_zero[i])
      );
      assign sup[i] = blank_lz && hi_zero[i];
    end
  endgenerate

  assign hex_nib = disp[dig];
  assign seg_out = (state == S_GUARD || sup[dig]) ? 7'h7F : seg_in;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (NDIG=4, SCAN_DIV=4, GUARD=1: slot 5, frame 20 clocks).
module tb_seg_scan_ctrl;
  localparam int NDIG = 4, SCAN_DIV = 4, GUARD = 1;

  logic        clk = 1'b0, rst = 1'b1, load = 1'b0, blank_lz = 1'b0;
  logic [15:0] value = 16'h0;
  logic        ack;
  logic [3:0]  hex_nib, dig_en_n;
  logic [6:0]  seg_in, seg_out;

  int n = 0, n_checks = 0, n_fail = 0;

  function automatic logic [6:0] dec7(input logic [3:0] h);
    case (h)
      4'h0: dec7 = 7'b1000000; 4'h1: dec7 = 7'b1111001;
      4'h2: dec7 = 7'b0100100; 4'h3: dec7 = 7'b0110000;
      4'h4: dec7 = 7'b0011001; 4'h5: dec7 = 7'b0010010;
      4'h6: dec7 = 7'b0000010; 4'h7: dec7 = 7'b1111000;
      4'h8: dec7 = 7'b0000000; 4'h9: dec7 = 7'b0010000;
      4'hA: dec7 = 7'b0001000; 4'hB: dec7 = 7'b0000011;
      4'hC: dec7 = 7'b1000110; 4'hD: dec7 = 7'b0100001;
      4'hE: dec7 = 7'b0000110; default: dec7 = 7'b0001110;
    endcase
  endfunction

  assign seg_in = dec7(hex_nib);

  seg_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
    .ack(ack), .hex_nib(hex_nib), .seg_in(seg_in), .seg_out(seg_out),
    .dig_en_n(dig_en_n)
  );

  always #5 clk = ~clk;

  // n counts edges since reset release; frame position is n % 20.
  task automatic step();
    @(posedge clk); #1; n++;
  endtask

  task automatic goto(input int m);
    int k = 0;
    while ((n % 20) != m && k < 40) begin step(); k++; end
  endtask

  task automatic capture(output logic [3:0][6:0] segs, output logic [3:0][3:0] ens);
    goto(1);
    for (int d = 0; d < 4; d++) begin
      goto(5 * d + 2);
      segs[d] = seg_out;
      ens[d]  = dig_en_n;
    end
  endtask

  task automatic wait_ack(input int budget, output int acks);
    acks = 0;
    repeat (budget) begin step(); if (ack === 1'b1) acks++; end
  endtask

  task automatic test_reset();
    logic [3:0] exp_en;
    logic [6:0] exp_seg;
    int m;
    rst = 1'b1; step(); step();
    n_checks++; if (dig_en_n !== 4'hF) begin n_fail++; $display("FAIL rst_en: got %b expected 1111", dig_en_n); end
    n_checks++; if (seg_out !== 7'h7F) begin n_fail++; $display("FAIL rst_seg: got %h expected 7f", seg_out); end
    n_checks++; if (hex_nib !== 4'h0) begin n_fail++; $display("FAIL rst_nib: got %h expected 0", hex_nib); end
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b expected 0", ack); end
    rst = 1'b0; n = 0;
    repeat (40) begin
      step();
      m = n % 20;
      if (m % 5 == 0) begin exp_en = 4'hF; exp_seg = 7'h7F; end
      else begin exp_en = ~(4'b0001 << ((m - 1) / 5)); exp_seg = 7'b1000000; end
      n_checks++; if (dig_en_n !== exp_en) begin n_fail++; $display("FAIL scan_en n=%0d: got %b expected %b", n, dig_en_n, exp_en); end
      n_checks++; if (seg_out !== exp_seg) begin n_fail++; $display("FAIL scan_seg n=%0d: got %b expected %b", n, seg_out, exp_seg); end
      n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL scan_ack n=%0d: got %b expected 0", n, ack); end
    end
  endtask

  task automatic test_load();
    logic [3:0][6:0] segs;
    logic [3:0][3:0] ens;
    int k = 0;
    goto(7);
    value = 16'h12AF; load = 1'b1; step(); load = 1'b0;
    while ((n % 20) != 0 && k < 30) begin
      n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL load_early_ack n=%0d: got %b expected 0", n, ack); end
      n_checks++; if (hex_nib !== 4'h0) begin n_fail++; $display("FAIL load_early_nib n=%0d: got %h expected 0", n, hex_nib); end
      step(); k++;
    end
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL load_ack: got %b expected 1", ack); end
    n_checks++; if (hex_nib !== 4'hF) begin n_fail++; $display("FAIL load_nib0: got %h expected f", hex_nib); end
    step();
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL load_ack_len: got %b expected 0", ack); end
    capture(segs, ens);
    n_checks++; if (segs[0] !== 7'b0001110) begin n_fail++; $display("FAIL load_d0: got %b expected 0001110", segs[0]); end
    n_checks++; if (segs[1] !== 7'b0001000) begin n_fail++; $display("FAIL load_d1: got %b expected 0001000", segs[1]); end
    n_checks++; if (segs[2] !== 7'b0100100) begin n_fail++; $display("FAIL load_d2: got %b expected 0100100", segs[2]); end
    n_checks++; if (segs[3] !== 7'b1111001) begin n_fail++; $display("FAIL load_d3: got %b expected 1111001", segs[3]); end
  endtask

  task automatic test_lz();
    logic [3:0][6:0] segs;
    logic [3:0][3:0] ens;
    int acks;
    blank_lz = 1'b1;
    goto(3);
    value = 16'h0030; load = 1'b1; step(); load = 1'b0;
    wait_ack(20, acks);
    n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL lz_ack: got %0d expected 1", acks); end
    capture(segs, ens);
    n_checks++; if (segs[0] !== 7'b1000000) begin n_fail++; $display("FAIL lz_d0: got %b expected 1000000", segs[0]); end
    n_checks++; if (segs[1] !== 7'b0110000) begin n_fail++; $display("FAIL lz_d1: got %b expected 0110000", segs[1]); end
    n_checks++; if (segs[2] !== 7'h7F) begin n_fail++; $display("FAIL lz_d2: got %b expected 1111111", segs[2]); end
    n_checks++; if (segs[3] !== 7'h7F) begin n_fail++; $display("FAIL lz_d3: got %b expected 1111111", segs[3]); end
    n_checks++; if (ens[2] !== 4'b1011) begin n_fail++; $display("FAIL lz_en2: got %b expected 1011", ens[2]); end
    n_checks++; if (ens[3] !== 4'b0111) begin n_fail++; $display("FAIL lz_en3: got %b expected 0111", ens[3]); end
    value = 16'h0000; load = 1'b1; step(); load = 1'b0;
    wait_ack(20, acks);
    n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL lz0_ack: got %0d expected 1", acks); end
    capture(segs, ens);
    n_checks++; if (segs[0] !== 7'b1000000) begin n_fail++; $display("FAIL lz0_d0: got %b expected 1000000", segs[0]); end
    n_checks++; if (segs[1] !== 7'h7F) begin n_fail++; $display("FAIL lz0_d1: got %b expected 1111111", segs[1]); end
    n_checks++; if (segs[3] !== 7'h7F) begin n_fail++; $display("FAIL lz0_d3: got %b expected 1111111", segs[3]); end
    blank_lz = 1'b0;
  endtask

  task automatic test_double_load();
    logic [3:0][6:0] segs;
    logic [3:0][3:0] ens;
    int acks;
    goto(3);
    value = 16'h1111; load = 1'b1; step(); load = 1'b0;
    goto(10);
    value = 16'h2222; load = 1'b1; step(); load = 1'b0;
    wait_ack(40, acks);
    n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL dbl_acks: got %0d expected 1", acks); end
    capture(segs, ens);
    for (int d = 0; d < 4; d++) begin
      n_checks++; if (segs[d] !== 7'b0100100) begin n_fail++; $display("FAIL dbl_d%0d: got %b expected 0100100", d, segs[d]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0][6:0] segs;
    logic [3:0][3:0] ens;
    int acks;
    goto(5);
    value = 16'h4444; load = 1'b1; step(); load = 1'b0;
    goto(19);
    value = 16'h5555; load = 1'b1; step(); load = 1'b0;
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack1: got %b expected 1", ack); end
    n_checks++; if (hex_nib !== 4'h4) begin n_fail++; $display("FAIL b2b_nib: got %h expected 4", hex_nib); end
    step();
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack1_len: got %b expected 0", ack); end
    capture(segs, ens);
    for (int d = 0; d < 4; d++) begin
      n_checks++; if (segs[d] !== 7'b0011001) begin n_fail++; $display("FAIL b2b_4_d%0d: got %b expected 0011001", d, segs[d]); end
    end
    wait_ack(20, acks);
    n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL b2b_ack2: got %0d expected 1", acks); end
    capture(segs, ens);
    for (int d = 0; d < 4; d++) begin
      n_checks++; if (segs[d] !== 7'b0010010) begin n_fail++; $display("FAIL b2b_5_d%0d: got %b expected 0010010", d, segs[d]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0][6:0] segs;
    logic [3:0][3:0] ens;
    int acks;
    goto(10);
    value = 16'h7777; load = 1'b1; step(); load = 1'b0;
    goto(12);
    n_checks++; if (dig_en_n !== 4'b1011) begin n_fail++; $display("FAIL mid_pre_en: got %b expected 1011", dig_en_n); end
    n_checks++; if (seg_out !== 7'b0010010) begin n_fail++; $display("FAIL mid_pre_seg: got %b expected 0010010", seg_out); end
    rst = 1'b1; #1;
    n_checks++; if (dig_en_n !== 4'hF) begin n_fail++; $display("FAIL mid_en: got %b expected 1111", dig_en_n); end
    n_checks++; if (seg_out !== 7'h7F) begin n_fail++; $display("FAIL mid_seg: got %b expected 1111111", seg_out); end
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mid_ack: got %b expected 0", ack); end
    n_checks++; if (hex_nib !== 4'h0) begin n_fail++; $display("FAIL mid_nib: got %h expected 0", hex_nib); end
    step(); step();
    rst = 1'b0; n = 0;
    wait_ack(25, acks);
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL mid_pend_drop: got %0d acks expected 0", acks); end
    capture(segs, ens);
    n_checks++; if (segs[0] !== 7'b1000000) begin n_fail++; $display("FAIL mid_d0: got %b expected 1000000", segs[0]); end
    n_checks++; if (segs[3] !== 7'b1000000) begin n_fail++; $display("FAIL mid_d3: got %b expected 1000000", segs[3]); end
    n_checks++; if (ens[0] !== 4'b1110) begin n_fail++; $display("FAIL mid_en0: got %b expected 1110", ens[0]); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_lz();
    test_double_load();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
